// File: rtl/uart_pkg.sv
// Shared UART constants: FSM encodings, bit-counter milestones, line levels and divider defaults.
// Used by both the transmit and receive paths so the two sides stay in step.
package uart_pkg;

    localparam logic [0:0] UART_STATE_IDLE = 1'b0;
    localparam logic [0:0] UART_STATE_RX   = 1'b1;   // same encoding as UART_STATE_TX

    localparam int         UART_BIT_CNT_W     = 4;
    localparam logic [3:0] UART_BIT_CNT_START = 4'd0;
    localparam logic [3:0] UART_BIT_CNT_MSB   = 4'd8;
    localparam logic [3:0] UART_BIT_CNT_STOP  = 4'd9;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    localparam int         UART_DIV_CNT_W = 9;
    localparam logic [8:0] UART_DIV_RATE  = 9'd260;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } uart_rx_word_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level; 2-cycle latency, no flow control.
// Resets to 1 so an idle-high serial line never looks like a start bit after reset.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling mid-bit; start detect 3 clocks after the pin falls, rx_end at the stop-bit centre.
// No flow control or overrun detection: the consumer must take rx_data before the next rx_end.
module uart_rx
    import uart_pkg::*;
#(
    parameter int                   DIV_CNT_W = UART_DIV_CNT_W,
    parameter logic [DIV_CNT_W-1:0] DIV_RATE  = DIV_CNT_W'(UART_DIV_RATE)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_busy,
    output logic       rx_end,
    output logic [7:0] rx_data,
    output logic       rx_err
);

    localparam logic [DIV_CNT_W-1:0] DIV_HALF = DIV_RATE >> 1;

    logic                      rx_s;
    logic [0:0]                state_q,   state_d;
    logic [DIV_CNT_W-1:0]      div_cnt_q, div_cnt_d;
    logic [UART_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]                sh_reg_q,  sh_reg_d;
    uart_rx_word_t             word_q,    word_d;
    logic                      rx_end_q,  rx_end_d;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sh_reg_d  = sh_reg_q;
        word_d    = word_q;
        rx_end_d  = 1'b0;

        if (state_q == UART_STATE_IDLE) begin
            if (rx_s == UART_START_BIT) begin
                state_d   = UART_STATE_RX;
                div_cnt_d = DIV_HALF;
                bit_cnt_d = UART_BIT_CNT_START;
            end
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - DIV_CNT_W'(1);
        end else begin
            div_cnt_d = DIV_RATE;
            if (bit_cnt_q == UART_BIT_CNT_START) begin
                // A start bit that is gone by its centre was a glitch.
                if (rx_s != UART_START_BIT) begin
                    state_d   = UART_STATE_IDLE;
                    bit_cnt_d = UART_BIT_CNT_START;
                end else begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q == UART_BIT_CNT_STOP) begin
                // Leave at the stop-bit centre so a back-to-back start edge is not missed.
                word_d.data = sh_reg_q;
                word_d.err  = (rx_s != UART_STOP_BIT);
                rx_end_d    = 1'b1;
                state_d     = UART_STATE_IDLE;
                bit_cnt_d   = UART_BIT_CNT_START;
            end else begin
                sh_reg_d  = {rx_s, sh_reg_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= UART_STATE_IDLE;
            div_cnt_q <= DIV_HALF;
            bit_cnt_q <= UART_BIT_CNT_START;
            sh_reg_q  <= '0;
            word_q    <= '0;
            rx_end_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sh_reg_q  <= sh_reg_d;
            word_q    <= word_d;
            rx_end_q  <= rx_end_d;
        end
    end

    assign rx_busy = (state_q == UART_STATE_RX);
    assign rx_end  = rx_end_q;
    assign rx_data = word_q.data;
    assign rx_err  = word_q.err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit: directed frames, glitch, reset abort, then random bytes.
module tb_uart_rx;

    localparam int         DIV_CNT_W = 9;
    localparam logic [8:0] DIV_RATE  = 9'd9;
    localparam int         BIT_CLKS  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_busy;
    logic       rx_end;
    logic [7:0] rx_data;
    logic       rx_err;

    always #5 clk = ~clk;

    uart_rx #(.DIV_CNT_W(DIV_CNT_W), .DIV_RATE(DIV_RATE)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_busy (rx_busy),
        .rx_end  (rx_end),
        .rx_data (rx_data),
        .rx_err  (rx_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: each frame the line carries yields {err, data} at its completion.
    logic [8:0] exp_q[$];
    int         end_cyc[$];
    int         cyc = 0;
    logic       prev_end = 1'b0;
    logic       prev_err = 1'b0;
    logic [8:0] mon_e;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (prev_end) begin
            chk("end_width", rx_end, 0);
            if (prev_err) chk("busy_resync", rx_busy, 1);
        end
        if (rx_end) begin
            end_cyc.push_back(cyc);
            chk("busy_at_end", rx_busy, 0);
            chk("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("rx_data", rx_data, mon_e[7:0]);
                chk("rx_err", rx_err, mon_e[8]);
                prev_err = mon_e[8];
            end else begin
                prev_err = 1'b0;
            end
        end
        prev_end = rx_end;
    end

    // All line tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit chk_busy);
        exp_q.push_back({~stop, b});
        rx = 1'b0;
        if (chk_busy) begin
            repeat (2) @(posedge clk);
            #1 chk("busy_pre", rx_busy, 0);
            @(posedge clk);
            #1 chk("busy_entry", rx_busy, 1);
            repeat (BIT_CLKS - 3) @(posedge clk);
            #1;
        end else begin
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        #1 chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int n0;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", rx_busy, 0);
        chk("rst_end", rx_end, 0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_err", rx_err, 0);
        reset = 1'b0;
        idle(1);

        send_frame(8'hA5, 1'b1, 1'b1);
        idle(1);
        drain("drain_a5");

        send_frame(8'hA5, 1'b0, 1'b0);
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(1);
        drain("drain_3c");

        n0 = end_cyc.size();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("glitch_busy", rx_busy, 1);
        rx = 1'b1;
        idle(2);
        chk("glitch_idle", rx_busy, 0);
        chk("glitch_no_end", end_cyc.size(), n0);
        chk("glitch_data_held", rx_data, 8'h3C);

        k = end_cyc.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(1);
        drain("drain_b2b");
        chk("b2b_count", end_cyc.size(), k + 2);
        if (end_cyc.size() >= k + 2)
            chk("b2b_gap", end_cyc[k+1] - end_cyc[k], 100);

        n0 = end_cyc.size();
        b = 8'h5A;
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        rx = b[4];
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_busy", rx_busy, 0);
        chk("abort_end", rx_end, 0);
        chk("abort_data", rx_data, 8'h00);
        chk("abort_err", rx_err, 0);
        idle(3);
        chk("abort_no_end", end_cyc.size(), n0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(1);
        drain("drain_81");

        n0 = end_cyc.size();
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        drain("drain_random");
        chk("random_count", end_cyc.size(), n0 + 256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the receive-side counterpart of the UART transmitter in the UART peripheral.
- Frame format: 8N1 (1 start bit, 8 data bits LSB-first, 1 stop bit).
- Bit period is DIV_RATE+1 clocks, identical to the transmitter, so the two pair directly.
- Samples each bit at mid-period and presents the received byte with a 1-cycle completion strobe and a framing-error flag to the UART bus interface.

Parameters:
- DIV_RATE, 9'd260: clocks per bit minus 1. Must match the transmitter.
- DIV_CNT_W, 9: width of the divider counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- rx  in  1  asynchronous serial input line; idles high
- rx_busy  out  1  high while state==RX
- rx_end  out  1  1-cycle pulse when the stop bit is sampled
- rx_data  out  8  last received byte; held until the next rx_end
- rx_err  out  1  framing error for the frame just ended; valid with rx_end, held until the next rx_end

Behaviour:
- Input synchronizer: 2-FF synchronizer on rx, reset value 1, giving rx_s. All logic uses rx_s only.
- Reset values:
  - state=IDLE, div_cnt=DIV_RATE/2, bit_cnt=START (0).
  - sh_reg=0, rx_data=0, rx_end=0, rx_err=0.
  - Both synchronizer FFs = 1.
- State IDLE:
  - rx_end<=0.
  - When rx_s==0: state<=RX, div_cnt<=DIV_RATE/2 (integer divide), bit_cnt<=START.
- State RX, div_cnt!=0: div_cnt<=div_cnt-1.
- State RX, div_cnt==0: div_cnt<=DIV_RATE, then by bit_cnt:
  - START: if rx_s==1 (glitch / false start), state<=IDLE, bit_cnt<=START, no rx_end. Otherwise bit_cnt<=1.
  - 1..8 (data): sh_reg<={rx_s, sh_reg[7:1]}, bit_cnt<=bit_cnt+1. Bit 8 is the MSB; after it bit_cnt becomes STOP (9).
  - STOP: rx_data<=sh_reg, rx_err<=~rx_s, rx_end<=1, state<=IDLE, bit_cnt<=START.
- Sample timing: the start-bit sample is taken DIV_RATE/2+1 clocks after entering RX. Each later sample follows DIV_RATE+1 clocks after the previous one.
- Latency: rx pin low to RX entry is 3 clocks (2 sync stages + 1 register).
- Stop-bit handling:
  - The receiver returns to IDLE at the stop-bit centre, not at the bit end.
  - If rx_s is high there, no new start is detected until it goes low. This allows back-to-back frames with a single stop bit.
  - If the stop bit is low (framing error), IDLE immediately sees rx_s==0 and starts a new frame attempt. This is intended: it resynchronises on break or misaligned data.
- rx_end is high for exactly 1 cycle per completed frame. rx_busy is combinational from state.
- rx_data and rx_err update only on rx_end, never mid-frame.
- Reset mid-frame: abandons the frame. No rx_end; outputs return to their reset values.
- The block has no overrun detection; the consumer must take rx_data before the next rx_end, i.e. within 10 bit periods.

Decomposition:
- Shared uart.h constants: UART_STATE_IDLE/UART_STATE_RX, UART_BIT_CNT_START/UART_BIT_CNT_MSB/UART_BIT_CNT_STOP (0/8/9), UART_START_BIT/UART_STOP_BIT, UART_DIV_RATE, UART_DIV_CNT_W.
- The new constant UART_STATE_RX equals UART_STATE_TX's encoding (1).
- One natural sub-module: uart_sync2, a 2-FF synchronizer with reset value 1.

Test Plan:
- DIV_RATE=9 (10 clk/bit): drive frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> one rx_end pulse; rx_data=0xA5; rx_err=0; rx_busy high from 3 clocks after the start edge until rx_end.
- Same frame with stop bit driven 0 -> rx_data=0xA5, rx_err=1, then rx_busy reasserts the next cycle. A following valid 0x3C frame after an idle-high gap of at least 1 bit -> rx_data=0x3C, rx_err=0.
- rx low for 3 clocks only, then high -> rx_busy pulses, returns to IDLE after the start sample, no rx_end, rx_data unchanged.
- Back-to-back frames 0x00 then 0xFF with 1 stop bit each, no gap -> two rx_end pulses 100 clocks apart, data 0x00 then 0xFF, rx_err=0 both.
- Assert reset for 1 cycle during data bit 4 of 0x5A -> no rx_end, outputs at reset values. The next full 0x81 frame is received correctly.
- Loopback uart_tx to uart_rx at default DIV_RATE, 256 random bytes -> every byte matches, no rx_err, one rx_end per tx_end.
